// File: rtl/alu_seg_pipe_if.sv
// alu_seg_pipe_if: operand/result handshake bundle for the segmented ALU pipe
interface alu_seg_pipe_if #(
  parameter int WIDTH = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             binv;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             co;
  logic             ovf;
  logic             zero;
  modport master (
    output in_valid, a, b, cin, binv, sel, out_ready,
    input  in_ready, out_valid, result, co, ovf, zero
  );
  modport slave (
    input  in_valid, a, b, cin, binv, sel, out_ready,
    output in_ready, out_valid, result, co, ovf, zero
  );
endinterface

// File: rtl/alu_seg_pipe.sv
// alu_seg_pipe: pipelined ALU, carry chain cut into SEG-bit stages with registered carries
module alu_seg_pipe #(
  parameter int WIDTH = 24,
  parameter int SEG   = 8
) (
  input logic          clk,
  input logic          rst,
  alu_seg_pipe_if.slave bus
);
  localparam int NSTG = WIDTH / SEG;
  logic adv;
  assign adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  if (SEG < 1 || WIDTH % SEG != 0) begin : g_bad
    $error("alu_seg_pipe: WIDTH must be a positive multiple of SEG");
  end
  for (genvar k = 0; k < NSTG; k++) begin : g
    // operands shrink by one segment per stage; finished result bits grow by one
    localparam int LW = WIDTH - k * SEG;
    logic                 iv;
    logic                 ic;
    logic [1:0]           op;
    logic [LW-1:0]        ia;
    logic [LW-1:0]        ib;
    logic [SEG:0]         s;
    logic [SEG-1:0]       seg;
    logic [(k+1)*SEG-1:0] nr;
    if (k == 0) begin : i
      assign iv = bus.in_valid;
      assign ia = bus.a;
      assign ib = bus.b ^ {WIDTH{bus.binv}};
      assign op = bus.sel;
      assign ic = bus.cin;
      assign nr = seg;
    end else begin : i
      assign iv = g[k-1].r.v;
      assign ia = g[k-1].r.ra;
      assign ib = g[k-1].r.rb;
      assign op = g[k-1].r.rs;
      assign ic = g[k-1].r.rc;
      assign nr = {seg, g[k-1].r.rr};
    end
    assign s   = {1'b0, ia[SEG-1:0]} + {1'b0, ib[SEG-1:0]} + {{SEG{1'b0}}, ic};
    assign seg = op[1] ? s[SEG-1:0] : op[0] ? ia[SEG-1:0] | ib[SEG-1:0] : ia[SEG-1:0] & ib[SEG-1:0];
    if (k < NSTG - 1) begin : r
      logic                 v;
      logic                 rc;
      logic [1:0]           rs;
      logic [LW-SEG-1:0]    ra;
      logic [LW-SEG-1:0]    rb;
      logic [(k+1)*SEG-1:0] rr;
      always_ff @(posedge clk)
        if (rst) v <= 1'b0;
        else if (adv) begin
          v  <= iv;
          ra <= ia[LW-1:SEG];
          rb <= ib[LW-1:SEG];
          rs <= op;
          rc <= s[SEG];
          rr <= nr;
        end
    end else begin : o
      logic             cm;
      logic             ov;
      logic [WIDTH-1:0] fr;
      // carry into the MSB recovered from the MSB sum bit and its operands
      assign cm = s[SEG-1] ^ ia[SEG-1] ^ ib[SEG-1];
      assign ov = cm ^ s[SEG];
      assign fr = &op ? {{(WIDTH-1){1'b0}}, nr[WIDTH-1] ^ ov} : nr;
      always_ff @(posedge clk)
        if (rst) begin
          bus.out_valid <= 1'b0;
          bus.result    <= '0;
          bus.co        <= 1'b0;
          bus.ovf       <= 1'b0;
          bus.zero      <= 1'b0;
        end else if (adv) begin
          bus.out_valid <= iv;
          if (iv) begin
            bus.result <= fr;
            bus.co     <= op[1] & s[SEG];
            bus.ovf    <= op[1] & ov;
            bus.zero   <= fr == '0;
          end
        end
    end
  end
endmodule

// File: tb/tb_alu_seg_pipe.sv
// tb_alu_seg_pipe: directed-vector bench for the 24-bit, 3-stage segmented ALU
module tb_alu_seg_pipe;
  localparam int W = 24;
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         bi;
    logic [1:0]   s;
    logic [W-1:0] r;
    logic         c;
    logic         o;
    logic         z;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  alu_seg_pipe_if #(.WIDTH(W)) bus();
  alu_seg_pipe #(.WIDTH(W), .SEG(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  int nv = 0;
  int nm = 0;
  int lat;
  logic [W-1:0] r;
  logic c, o, z;

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic bi, input logic [1:0] s);
    bus.a = a; bus.b = b; bus.cin = ci; bus.binv = bi; bus.sel = s;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic bi, input logic [1:0] s);
    @(negedge clk);
    drive(a, b, ci, bi, s);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    r = bus.result; c = bus.co; o = bus.ovf; z = bus.zero;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nv++;
    if ({bus.out_valid, bus.result, bus.co, bus.ovf, bus.zero} !== '0) begin
      nm++;
      $display("FAIL reset_outputs: got valid=%b result=%h co=%b ovf=%b zero=%b, want all 0",
               bus.out_valid, bus.result, bus.co, bus.ovf, bus.zero);
    end
    nv++;
    if (bus.in_ready !== 1'b1) begin
      nm++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_add();
    vec_t tv [3];
    tv = '{'{24'h0000FF, 24'h000001, 1'b0, 1'b0, 2'b10, 24'h000100, 1'b0, 1'b0, 1'b0},
           '{24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 2'b10, 24'h000000, 1'b1, 1'b0, 1'b1},
           '{24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 2'b10, 24'h800000, 1'b0, 1'b1, 1'b0}};
    foreach (tv[n]) begin
      run_op(tv[n].a, tv[n].b, tv[n].ci, tv[n].bi, tv[n].s);
      nv++;
      if ({lat, r, c, o, z} !== {32'd3, tv[n].r, tv[n].c, tv[n].o, tv[n].z}) begin
        nm++;
        $display("FAIL add[%0d]: got lat=%0d result=%h co=%b ovf=%b zero=%b, want lat=3 result=%h co=%b ovf=%b zero=%b",
                 n, lat, r, c, o, z, tv[n].r, tv[n].c, tv[n].o, tv[n].z);
      end
    end
  endtask

  task automatic test_sub();
    vec_t tv [4];
    tv = '{'{24'h000005, 24'h000007, 1'b1, 1'b1, 2'b10, 24'hFFFFFE, 1'b0, 1'b0, 1'b0},
           '{24'h000005, 24'h000007, 1'b1, 1'b1, 2'b11, 24'h000001, 1'b0, 1'b0, 1'b0},
           '{24'h000007, 24'h000005, 1'b1, 1'b1, 2'b11, 24'h000000, 1'b1, 1'b0, 1'b1},
           '{24'h800000, 24'h000001, 1'b1, 1'b1, 2'b11, 24'h000001, 1'b1, 1'b1, 1'b0}};
    foreach (tv[n]) begin
      run_op(tv[n].a, tv[n].b, tv[n].ci, tv[n].bi, tv[n].s);
      nv++;
      if ({lat, r, c, o, z} !== {32'd3, tv[n].r, tv[n].c, tv[n].o, tv[n].z}) begin
        nm++;
        $display("FAIL sub_slt[%0d]: got lat=%0d result=%h co=%b ovf=%b zero=%b, want lat=3 result=%h co=%b ovf=%b zero=%b",
                 n, lat, r, c, o, z, tv[n].r, tv[n].c, tv[n].o, tv[n].z);
      end
    end
  endtask

  task automatic test_logic();
    vec_t tv [4];
    tv = '{'{24'hF0F0F0, 24'h0FF00F, 1'b0, 1'b0, 2'b00, 24'h00F000, 1'b0, 1'b0, 1'b0},
           '{24'hF0F0F0, 24'h0FF00F, 1'b1, 1'b0, 2'b01, 24'hFFF0FF, 1'b0, 1'b0, 1'b0},
           '{24'hF0F0F0, 24'h0FF00F, 1'b0, 1'b1, 2'b00, 24'hF000F0, 1'b0, 1'b0, 1'b0},
           '{24'hF0F0F0, 24'h0F0F0F, 1'b1, 1'b0, 2'b00, 24'h000000, 1'b0, 1'b0, 1'b1}};
    foreach (tv[n]) begin
      run_op(tv[n].a, tv[n].b, tv[n].ci, tv[n].bi, tv[n].s);
      nv++;
      if ({lat, r, c, o, z} !== {32'd3, tv[n].r, tv[n].c, tv[n].o, tv[n].z}) begin
        nm++;
        $display("FAIL logic[%0d]: got lat=%0d result=%h co=%b ovf=%b zero=%b, want lat=3 result=%h co=%b ovf=%b zero=%b",
                 n, lat, r, c, o, z, tv[n].r, tv[n].c, tv[n].o, tv[n].z);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ea [6];
    logic [W-1:0] eb [6];
    logic [W-1:0] held;
    int i = 0;
    int j = 0;
    for (int k = 0; k < 6; k++) begin
      ea[k] = 24'h0000FF + 24'(k * 24'h010000);
      eb[k] = 24'h000001 + 24'(k * 24'h001000);
    end
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc == 5 || cyc == 6);
      if (i < 6) begin
        drive(ea[i], eb[i], 1'b0, 1'b0, 2'b10);
        bus.in_valid = 1'b1;
      end else bus.in_valid = 1'b0;
      #1;
      if (!bus.out_ready) begin
        nv++;
        if (bus.in_ready !== 1'b0) begin
          nm++;
          $display("FAIL stall_in_ready: cycle %0d got %b want 0", cyc, bus.in_ready);
        end
      end
      if (cyc == 5) held = bus.result;
      if (cyc == 6) begin
        nv++;
        if (bus.result !== held || bus.out_valid !== 1'b1) begin
          nm++;
          $display("FAIL stall_hold: got valid=%b result=%h want valid=1 result=%h",
                   bus.out_valid, bus.result, held);
        end
      end
      if (bus.in_valid && bus.in_ready) i++;
      if (bus.out_valid && bus.out_ready) begin
        nv++;
        if (j >= 6 || bus.result !== ea[j] + eb[j]) begin
          nm++;
          $display("FAIL stream[%0d]: got %h want %h", j, bus.result, j < 6 ? ea[j] + eb[j] : 24'h0);
        end
        j++;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    nv++;
    if (j !== 6) begin
      nm++;
      $display("FAIL stream_count: got %0d results want 6", j);
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(24'(k + 1), 24'h000001, 1'b0, 1'b0, 2'b10);
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    nv++;
    if (bus.out_valid !== 1'b1) begin
      nm++;
      $display("FAIL midstream_full: got out_valid=%b want 1", bus.out_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nv++;
    if ({bus.out_valid, bus.result, bus.co, bus.ovf, bus.zero, bus.in_ready} !== {1'b0, 24'h0, 3'b000, 1'b1}) begin
      nm++;
      $display("FAIL midstream_reset: got valid=%b result=%h co=%b ovf=%b zero=%b ready=%b, want 0/000000/0/0/0/1",
               bus.out_valid, bus.result, bus.co, bus.ovf, bus.zero, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    run_op(24'h000010, 24'h000020, 1'b0, 1'b0, 2'b10);
    nv++;
    if ({lat, r} !== {32'd3, 24'h000030}) begin
      nm++;
      $display("FAIL post_reset_op: got lat=%0d result=%h want lat=3 result=000030", lat, r);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive('0, '0, 1'b0, 1'b0, 2'b00);
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nm);
    $finish;
  end
endmodule
